// File: rtl/alu_72_if.sv
// alu_72_if: operand/result bundle for the 72-bit ALU.
//   op           4   operation select
//   A, B         72  operands (B also supplies the immediate for ops 6-8)
//   C            72  registered result
//   DivZeroError 1   registered divide-by-zero flag
// master drives op/A/B and observes the results; slave is the ALU side.
interface alu_72_if;
  logic [3:0]  op;
  logic [71:0] A;
  logic [71:0] B;
  logic [71:0] C;
  logic        DivZeroError;

  modport master (output op, A, B, input C, DivZeroError);
  modport slave  (input op, A, B, output C, DivZeroError);
endinterface

// File: rtl/alu_72.sv
// alu_72: 72-bit unsigned integer ALU with a single output register stage.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, clears C and DivZeroError
//   bus  alu_72_if.slave: op/A/B in, C/DivZeroError out (1-cycle latency)
module alu_72 (
  input  logic      clk,
  input  logic      rst,
  alu_72_if.slave   bus
);

  logic [71:0] imm;
  logic [71:0] res;
  logic        dz;
  logic        a_nz;
  logic        b_nz;
  logic        sh_big;

  assign imm  = {17'b0, bus.B[54:0]};
  assign a_nz = |bus.A;
  assign b_nz = |bus.B;
  // Shift amounts of 72 or more flush the operand entirely.
  assign sh_big = (|bus.B[71:7]) || (bus.B[6:0] > 7'd71);

  always_comb begin
    res = '0;
    dz  = 1'b0;
    case (bus.op)
      4'd0:  res = bus.A + bus.B;
      4'd1:  res = bus.A - bus.B;
      4'd2:  res = bus.A * bus.B;
      4'd3: begin
        if (b_nz) res = bus.A / bus.B;
        else      dz  = 1'b1;
      end
      4'd4:  res = sh_big ? 72'd0 : (bus.A << bus.B[6:0]);
      4'd5:  res = sh_big ? 72'd0 : (bus.A >> bus.B[6:0]);
      4'd6:  res = bus.A + imm;
      4'd7:  res = bus.A - imm;
      4'd8:  res = bus.A & imm;
      4'd9:  res = {71'b0, a_nz && b_nz};
      4'd10: res = {71'b0, a_nz || b_nz};
      4'd11: res = bus.A ^ bus.B;
      4'd12: res = {71'b0, bus.A == bus.B};
      4'd13: res = {71'b0, bus.A != bus.B};
      4'd14: res = {71'b0, bus.A <  bus.B};
      default: res = {71'b0, bus.A >  bus.B};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.C            <= '0;
      bus.DivZeroError <= 1'b0;
    end else begin
      bus.C            <= res;
      bus.DivZeroError <= dz;
    end
  end

endmodule

// File: tb/tb_alu_72.sv
module tb_alu_72;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  alu_72_if bus ();
  alu_72 u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [71:0] a;
    logic [71:0] b;
    logic [71:0] c;
    logic        dz;
  } vec_t;

  vec_t vecs[$];

  localparam logic [71:0] ALL1 = {72{1'b1}};

  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model built from the arithmetic rules with wide intermediates.
  task automatic model(input logic [3:0] op, input logic [71:0] a, input logic [71:0] b,
                       output logic [71:0] c, output logic dz);
    logic [143:0] wide;
    logic [71:0]  imm;
    imm  = b % (72'd1 << 55);
    dz   = 1'b0;
    c    = '0;
    wide = '0;
    case (op)
      0: begin wide = 144'(a) + 144'(b); c = wide[71:0]; end
      1: begin wide = (144'(1) << 72) + 144'(a) - 144'(b); c = wide[71:0]; end
      2: begin wide = 144'(a) * 144'(b); c = wide[71:0]; end
      3: if (b == 0) dz = 1'b1; else c = a / b;
      4: if (b < 72) begin wide = 144'(a) * (144'(1) << b); c = wide[71:0]; end
      5: if (b < 72) c = a / (72'd1 << b);
      6: begin wide = 144'(a) + 144'(imm); c = wide[71:0]; end
      7: begin wide = (144'(1) << 72) + 144'(a) - 144'(imm); c = wide[71:0]; end
      8: c = a & imm;
      9: c = ((a != 0) && (b != 0)) ? 72'd1 : 72'd0;
      10: c = ((a != 0) || (b != 0)) ? 72'd1 : 72'd0;
      11: c = a ^ b;
      12: c = (a == b) ? 72'd1 : 72'd0;
      13: c = (a != b) ? 72'd1 : 72'd0;
      14: c = (a < b) ? 72'd1 : 72'd0;
      default: c = (a > b) ? 72'd1 : 72'd0;
    endcase
  endtask

  // Called at a negedge: drive inputs, check after the edge, then scramble
  // inputs mid-cycle and confirm the registered outputs do not move.
  task automatic run(input logic [3:0] op, input logic [71:0] a, input logic [71:0] b,
                     input logic [71:0] ec, input logic edz, input string nm);
    bus.op = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    chk({nm, ".C"}, bus.C, ec);
    chk({nm, ".dz"}, {71'b0, bus.DivZeroError}, {71'b0, edz});
    bus.op = 4'($urandom); bus.A = {$urandom, $urandom, $urandom} ; bus.B = 72'($urandom);
    #2;
    chk({nm, ".hold"}, bus.C, ec);
    @(negedge clk);
  endtask

  function automatic logic [71:0] rnd72();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[71:0];
  endfunction

  initial begin
    logic [3:0]  rop;
    logic [71:0] ra, rb, ec;
    logic        edz;

    vecs.push_back('{4'd1,  72'd50,  72'd30,  72'd20,  1'b0});
    vecs.push_back('{4'd2,  72'd15,  72'd2,   72'd30,  1'b0});
    vecs.push_back('{4'd3,  72'd100, 72'd10,  72'd10,  1'b0});
    vecs.push_back('{4'd1,  72'd0,   72'd1,   ALL1,    1'b0});
    vecs.push_back('{4'd4,  72'd5,   72'd1,   72'd10,  1'b0});
    vecs.push_back('{4'd5,  72'd16,  72'd1,   72'd8,   1'b0});
    vecs.push_back('{4'd4,  72'd1,   72'd72,  72'd0,   1'b0});
    vecs.push_back('{4'd6,  72'd25,  72'd100, 72'd125, 1'b0});
    vecs.push_back('{4'd7,  72'd50,  72'd10,  72'd40,  1'b0});
    vecs.push_back('{4'd8,  72'd60,  72'd15,  72'd12,  1'b0});
    vecs.push_back('{4'd6,  72'd0,   (72'd1 << 55) + 72'd3, 72'd3, 1'b0});
    vecs.push_back('{4'd9,  72'd1,   72'd1,   72'd1,   1'b0});
    vecs.push_back('{4'd10, 72'd1,   72'd0,   72'd1,   1'b0});
    vecs.push_back('{4'd11, 72'd1,   72'd2,   72'd3,   1'b0});
    vecs.push_back('{4'd12, 72'd100, 72'd100, 72'd1,   1'b0});
    vecs.push_back('{4'd13, 72'd100, 72'd50,  72'd1,   1'b0});
    vecs.push_back('{4'd14, 72'd10,  72'd20,  72'd1,   1'b0});
    vecs.push_back('{4'd15, 72'd30,  72'd20,  72'd1,   1'b0});
    vecs.push_back('{4'd15, 72'd20,  72'd30,  72'd0,   1'b0});
    vecs.push_back('{4'd3,  72'd20,  72'd0,   72'd0,   1'b1});
    vecs.push_back('{4'd12, 72'd20,  72'd0,   72'd0,   1'b0});
    vecs.push_back('{4'd5,  ALL1,    72'd71,  72'd1,   1'b0});
    vecs.push_back('{4'd5,  ALL1,    ALL1,    72'd0,   1'b0});
    vecs.push_back('{4'd0,  ALL1,    72'd1,   72'd0,   1'b0});

    bus.op = 4'd0; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    chk("reset.C", bus.C, 72'd0);
    chk("reset.dz", {71'b0, bus.DivZeroError}, 72'd0);
    rst = 1'b0;

    // Set DivZeroError and a nonzero C, then reset asynchronously mid-cycle.
    run(4'd3, 72'd20, 72'd0, 72'd0, 1'b1, "pre_rst_dz");
    bus.op = 4'd0; bus.A = 72'd7; bus.B = 72'd8;
    @(posedge clk); #1;
    chk("pre_rst.C", bus.C, 72'd15);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.C", bus.C, 72'd0);
    chk("async_rst.dz", {71'b0, bus.DivZeroError}, 72'd0);
    // Pending operation presented across an edge under reset is discarded.
    bus.op = 4'd3; bus.A = 72'd9; bus.B = 72'd0;
    @(posedge clk); #1;
    chk("rst_discard.C", bus.C, 72'd0);
    chk("rst_discard.dz", {71'b0, bus.DivZeroError}, 72'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release.dz", {71'b0, bus.DivZeroError}, 72'd0);
    @(negedge clk);

    run(4'd0, 72'd10, 72'd20, 72'd30, 1'b0, "post_rst_add");

    foreach (vecs[i])
      run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].dz, $sformatf("vec%0d", i));

    for (int k = 0; k < 400; k++) begin
      rop = 4'($urandom);
      ra  = rnd72();
      case ($urandom_range(0, 3))
        0: rb = 72'd0;
        1: rb = 72'($urandom_range(0, 80));
        2: rb = 72'($urandom);
        default: rb = rnd72();
      endcase
      if ($urandom_range(0, 7) == 0) ra = rb;
      if ($urandom_range(0, 7) == 0) ra = 72'($urandom_range(0, 3));
      model(rop, ra, rb, ec, edz);
      run(rop, ra, rb, ec, edz, $sformatf("rnd%0d_op%0d", k, rop));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
